// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; master drives operands and start, slave returns results.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Serial adder, CHUNK bits per clock; latency WIDTH/CHUNK cycles start->done; start ignored while busy.
// SERIAL_ADDER_SUB_EN adds a sub select computing a + ~b + 1 (cin ignored).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;

  logic [CHUNK:0]       slice_sum;
  logic [WIDTH-1:0]     a_d, b_d, part_d, b_cap;
  logic [WIDTH+CHUNK-1:0] part_ext;
  logic [CNT_W-1:0]     cnt_d;
  logic                 carry_d, carry_cap, last;

  // Operands shift right so the active slice is always at the bottom; the
  // result shifts in from the top and is fully aligned after N slices.
  always_comb begin
    slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    a_d       = a_q >> CHUNK;
    b_d       = b_q >> CHUNK;
    part_ext  = {slice_sum[CHUNK-1:0], part_q};
    part_d    = part_ext[WIDTH+CHUNK-1:CHUNK];
    carry_d   = slice_sum[CHUNK];
    cnt_d     = cnt_q + CNT_W'(1);
    last      = (cnt_q == CNT_W'(N - 1));
`ifdef SERIAL_ADDER_SUB_EN
    b_cap     = bus.sub ? ~bus.b : bus.b;
    carry_cap = bus.sub ? 1'b1 : bus.cin;
`else
    b_cap     = bus.b;
    carry_cap = bus.cin;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= b_cap;
            carry_q <= carry_cap;
            part_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          part_q  <= part_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_d;
          if (last) begin
            sum_q   <= part_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter CHUNK, default 1, giving the bits added per clock; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  request to begin an addition using the current a, b and cin.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: cin  input  1  carry-in.
REQ-010 Port: sub  input  1  subtract select; present only when SERIAL_ADDER_SUB_EN is defined.
REQ-011 Port: busy  output  1  high while an addition is in progress.
REQ-012 Port: done  output  1  one-cycle pulse marking that sum and cout have been updated.
REQ-013 Port: sum  output  WIDTH  result, registered.
REQ-014 Port: cout  output  1  carry-out of the MSB, registered.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at an edge SHALL capture a, b and cin into internal registers, clear the chunk counter and move to RUN.
REQ-017 In IDLE or DONE, start=0 at an edge SHALL move to IDLE.
REQ-018 In RUN, each edge SHALL add one CHUNK-bit slice of the captured operands, LSB slice first, together with the running carry; the slice sum SHALL go to the partial result and the slice carry SHALL become the next running carry.
REQ-019 With N = WIDTH/CHUNK, the block SHALL process N slices on edges t0+1 .. t0+N, where t0 is the start edge.
REQ-020 At edge t0+N the block SHALL load sum and cout from the partial result and final carry, and move to DONE.
REQ-021 Latency from start edge to done=1 SHALL be exactly N cycles.
REQ-022 busy SHALL be 1 exactly when state is RUN.
REQ-023 done SHALL be 1 exactly when state is DONE, i.e. for one cycle per completed addition.
REQ-024 start SHALL be ignored while in RUN; captured operands SHALL NOT change during RUN.
REQ-025 start=1 in the DONE cycle SHALL be accepted, giving back-to-back operations with one done cycle between them.
REQ-026 sum and cout SHALL hold the previous result from the edge after done until the next completion; they SHALL change only at REQ-020 or at reset.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH on sum, with cout = bit WIDTH of a + b + cin.
REQ-028 Inputs a, b, cin and sub SHALL be sampled only at the start edge.

Reset
REQ-029 rst=1 at an edge SHALL set state to IDLE and set busy=0, done=0, sum=0 and cout=0; the chunk counter, captured operands and running carry SHALL also be cleared.
REQ-030 rst SHALL take priority over start and abort any addition in progress; no done pulse SHALL follow an aborted operation.

Configuration
REQ-031 When SERIAL_ADDER_SUB_EN is defined, the sub port SHALL exist; sub=1 at the start edge SHALL compute a + ~b + 1 with cin ignored, giving cout=1 when no borrow occurs; sub=0 SHALL add as in REQ-027.
REQ-032 When SERIAL_ADDER_SUB_EN is undefined, the sub port and its logic SHALL be absent and the block SHALL always add.

Verification
REQ-033 Test: WIDTH=8, CHUNK=1; a=0xFF, b=0x01, cin=0, start pulse -> busy high 8 cycles, then done=1 with sum=0x00 and cout=1.
REQ-034 Test: WIDTH=8, CHUNK=4; a=0x5A, b=0xA5, cin=1 -> done after 2 cycles with sum=0x00 and cout=1.
REQ-035 Test: start held high during RUN with changing a and b -> result reflects the first captured operands only; one done per accepted start.
REQ-036 Test: start in the DONE cycle with a=0x03, b=0x04 -> second done exactly 8 cycles later with sum=0x07 and cout=0; the first result stays held until then.
REQ-037 Test: rst=1 on the 3rd RUN cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, and no done pulse follows.
REQ-038 Test: with SERIAL_ADDER_SUB_EN defined, a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
